// File: rtl/pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : pipeline_pkg                                                 |
// | Description : Shared types and defaults for the pipeline memory subsystem. |
// |               Holds the arbiter state encoding, the owner encoding and the |
// |               default memory latency / DM streak limit used by             |
// |               pipeline_top, mem_arbiter and the memory model.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package pipeline_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DRAIN = 2'd2
  } arb_state_e;

  // Which requester currently owns the memory port
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_LATENCY       = 2;
  localparam int DEF_MAX_DM_STREAK = 3;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/mem_arb_priority.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arb_priority                                             |
// | Description : IF/DM selection for the memory arbiter. DM normally wins;    |
// |               a streak counter of DM grants taken while IF was waiting     |
// |               forces IF through once it reaches MAX_DM_STREAK.             |
// | Ports       : clk, rst      - clock, synchronous active-high reset         |
// |               if_req        - fetch request pending                        |
// |               dm_req        - load/store request pending                   |
// |               grant_en      - a grant is being issued this cycle           |
// |               sel_dm        - 1 = grant goes to DM, 0 = grant goes to IF   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arb_priority #(
  parameter int MAX_DM_STREAK = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic dm_req,
  input  logic grant_en,
  output logic sel_dm
);

  localparam int              SW           = $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0]   C_STREAK_MAX = SW'(MAX_DM_STREAK);

  logic [SW-1:0] r_streak;
  logic          w_if_forced;

  // IF is pushed through only when it is actually waiting
  assign w_if_forced = if_req && (r_streak == C_STREAK_MAX);
  assign sel_dm      = dm_req && !w_if_forced;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_streak <= '0;
    end else if (grant_en) begin
      if (sel_dm && if_req) begin
        // DM jumped ahead of a waiting fetch
        if (r_streak != C_STREAK_MAX) begin
          r_streak <= r_streak + 1'b1;
        end
      end else begin
        // IF grant, or DM grant with nobody waiting
        r_streak <= '0;
      end
    end
  end

endmodule : mem_arb_priority
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_arbiter                                                  |
// | Description : Shares one single-ported memory between instruction fetch    |
// |               (IF) and data memory (DM). One transaction outstanding at a  |
// |               time; fixed LATENCY; done pulse and read data routed to the  |
// |               owner; stall signals back to the pipeline.                   |
// | Ports       : clk, rst                     - clock, sync active-high reset |
// |               if_req/if_addr               - fetch request                 |
// |               if_done/if_rdata             - fetch completion              |
// |               dm_req/we/addr/wdata/wmask   - load/store request            |
// |               dm_done/dm_rdata             - load/store completion         |
// |               stall_if/stall_mem           - pipeline stalls               |
// |               mem_req/we/addr/wdata/wmask  - memory issue strobe/fields    |
// |               mem_rdata                    - memory read data              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_arbiter
  import pipeline_pkg::*;
#(
  parameter int LATENCY       = DEF_LATENCY,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int AW            = 32,
  parameter int DW            = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_done,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [AW-1:0]   dm_addr,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  output logic            dm_done,
  output logic [DW-1:0]   dm_rdata,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int            CW         = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] C_CNT_LOAD = CW'(LATENCY - 1);

  arb_state_e    r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt;
  logic          r_we,    w_we_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;

  logic w_grant_en;
  logic w_sel_dm;
  logic w_done;

  // Grants only happen from IDLE; reset suppresses any issue in its cycle
  assign w_grant_en = (r_state == ST_IDLE) && (if_req || dm_req) && !rst;
  assign w_done     = (r_state == ST_BUSY) && (r_cnt == '0) && !rst;

  mem_arb_priority #(
    .MAX_DM_STREAK (MAX_DM_STREAK)
  ) u_priority (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .dm_req   (dm_req),
    .grant_en (w_grant_en),
    .sel_dm   (w_sel_dm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_we    <= w_we_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_we_nxt    = r_we;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_en) begin
          w_state_nxt = ST_BUSY;
          w_owner_nxt = w_sel_dm ? OWN_DM : OWN_IF;
          w_we_nxt    = w_sel_dm && dm_we;
          w_cnt_nxt   = C_CNT_LOAD;
        end
      end
      ST_BUSY: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_DRAIN: begin
        // Gives the finished requester a cycle to drop its request
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Issue fields are zero whenever there is no strobe
  assign mem_req   = w_grant_en;
  assign mem_we    = w_grant_en && w_sel_dm && dm_we;
  assign mem_addr  = !w_grant_en ? '0 : (w_sel_dm ? dm_addr : if_addr);
  assign mem_wdata = (w_grant_en && w_sel_dm) ? dm_wdata : '0;
  assign mem_wmask = (w_grant_en && w_sel_dm) ? dm_wmask : '0;

  assign if_done   = w_done && (r_owner == OWN_IF);
  assign dm_done   = w_done && (r_owner == OWN_DM);
  assign if_rdata  = if_done ? mem_rdata : '0;
  assign dm_rdata  = (dm_done && !r_we) ? mem_rdata : '0;

  assign stall_if  = if_req && !if_done;
  assign stall_mem = dm_req && !dm_done;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                               |
// | Description : Self-checking bench for mem_arbiter. A memory model with     |
// |               fixed latency, IF/DM requester agents and a cycle-level      |
// |               reference of the arbitration rules.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int LAT  = 2;
  localparam int MAXS = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_done;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_wmask;
  logic          dm_done;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wmask;
  logic [DW-1:0] mem_rdata;

  mem_arbiter #(
    .LATENCY       (LAT),
    .MAX_DM_STREAK (MAXS),
    .AW            (AW),
    .DW            (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_done   (if_done),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_wmask  (dm_wmask),
    .dm_done   (dm_done),
    .dm_rdata  (dm_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [31:0] init_val(input int i);
    return 32'h1357_9BDF ^ (32'(i) * 32'h0101_0101) ^ (32'(i) << 20);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory model: read at issue, write commits at data time
  typedef struct packed {
    logic        v;
    logic        we;
    logic [7:0]  idx;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic [31:0] rd;
  } ment_t;

  logic [31:0] mem [256];
  ment_t       pipe [LAT];
  bit          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (pipe[LAT-1].v && pipe[LAT-1].we && !rst) begin
      mem[pipe[LAT-1].idx] <= merge(mem[pipe[LAT-1].idx], pipe[LAT-1].wd, pipe[LAT-1].wm);
    end
    if (rst) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      pipe[0] <= {mem_req, mem_we, mem_addr[9:2], mem_wdata, mem_wmask, mem[mem_addr[9:2]]};
    end
  end

  assign mem_rdata = pipe[LAT-1].v ? pipe[LAT-1].rd : 32'hA5A5_5A5A;

  // ---------------- scoreboard state
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model
  logic [31:0] ref_mem [256];
  int          cyc, free_at, done_at, streak;
  bit          active, own_dm, m_we;
  logic [7:0]  m_idx;
  logic [31:0] m_wd;
  logic [3:0]  m_wm;

  // requester agents
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  wm;
  } dreq_t;
  logic [31:0] if_q [$];
  dreq_t       dm_q [$];
  bit          if_drop, dm_drop;
  int          gap_pct;

  // observations of the DUT
  int          g_cyc [$];
  bit          g_dm  [$];
  logic [31:0] if_rd_log [$];
  logic [31:0] dm_rd_log [$];

  task automatic clear_logs();
    g_cyc.delete(); g_dm.delete(); if_rd_log.delete(); dm_rd_log.delete();
  endtask

  // One clock cycle: drive agents, check outputs, advance the reference.
  task automatic step();
    bit e_done, e_if, e_dm, grant, g_sel_dm;
    dreq_t d;
    if (if_drop) begin
      if_req = 1'b0; if_drop = 1'b0;
    end else if (!if_req && if_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      if_addr = if_q.pop_front(); if_req = 1'b1;
    end
    if (dm_drop) begin
      dm_req = 1'b0; dm_drop = 1'b0;
    end else if (!dm_req && dm_q.size() > 0 && $urandom_range(99) >= gap_pct) begin
      d = dm_q.pop_front();
      dm_we = d.we; dm_addr = d.addr; dm_wdata = d.wd; dm_wmask = d.wm; dm_req = 1'b1;
    end
    #1;
    e_done   = active && (cyc == done_at) && !rst;
    e_if     = e_done && !own_dm;
    e_dm     = e_done && own_dm;
    grant    = !rst && !active && (cyc >= free_at) && (if_req || dm_req);
    g_sel_dm = dm_req && !(if_req && streak == MAXS);

    chk("mem_req",   mem_req,   grant);
    chk("if_done",   if_done,   e_if);
    chk("dm_done",   dm_done,   e_dm);
    chk("stall_if",  stall_if,  if_req && !e_if);
    chk("stall_mem", stall_mem, dm_req && !e_dm);
    if (grant) begin
      chk("mem_addr", mem_addr, g_sel_dm ? dm_addr : if_addr);
      chk("mem_we",   mem_we,   g_sel_dm && dm_we);
      if (g_sel_dm && dm_we) begin
        chk("mem_wdata", mem_wdata, dm_wdata);
        chk("mem_wmask", mem_wmask, dm_wmask);
      end
    end
    if (e_if) chk("if_rdata", if_rdata, ref_mem[m_idx]);
    if (e_dm) chk("dm_rdata", dm_rdata, m_we ? 32'h0 : ref_mem[m_idx]);

    if (mem_req) begin
      g_cyc.push_back(cyc);
      g_dm.push_back(dm_req && (!if_req || mem_addr != if_addr));
    end
    if (if_done) if_rd_log.push_back(if_rdata);
    if (dm_done) dm_rd_log.push_back(dm_rdata);

    if (rst) begin
      active = 1'b0; free_at = cyc + 1; streak = 0;
    end else begin
      if (e_done) begin
        active = 1'b0;
        if (own_dm && m_we) ref_mem[m_idx] = merge(ref_mem[m_idx], m_wd, m_wm);
        if (own_dm) dm_drop = 1'b1; else if_drop = 1'b1;
      end
      if (grant) begin
        active  = 1'b1;
        own_dm  = g_sel_dm;
        m_we    = g_sel_dm && dm_we;
        m_idx   = g_sel_dm ? dm_addr[9:2] : if_addr[9:2];
        m_wd    = dm_wdata;
        m_wm    = dm_wmask;
        done_at = cyc + LAT;
        free_at = cyc + LAT + 2;
        streak  = (g_sel_dm && if_req) ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    if_q.delete(); dm_q.delete(); if_drop = 1'b0; dm_drop = 1'b0;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic run_quiet(input int budget);
    int k;
    k = 0;
    while ((if_q.size() > 0 || dm_q.size() > 0 || if_req || dm_req || active ||
            if_drop || dm_drop) && k < budget) begin
      step(); k++;
    end
    if (k >= budget) begin
      n_cmp++; n_bad++;
      $display("FAIL quiesce: requests still pending after %0d cycles, required idle", k);
    end
  endtask

  function automatic dreq_t mk(input logic we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] wm);
    dreq_t d;
    d.we = we; d.addr = a; d.wd = wd; d.wm = wm;
    return d;
  endfunction

  // reset-state vectors: requests applied while rst is held
  typedef struct {
    logic ir, dr;
    logic e_si, e_sm;
  } rvec_t;
  rvec_t tbl [4];

  initial begin
    dreq_t d;
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; dm_wmask = '0;
    cyc = 0; free_at = 0; done_at = 0; streak = 0; active = 1'b0; own_dm = 1'b0;
    m_we = 1'b0; m_idx = '0; m_wd = '0; m_wm = '0;
    if_drop = 1'b0; dm_drop = 1'b0; gap_pct = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(negedge clk);
    reset_dut(2);

    // ---- reset state table
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_req = tbl[i].ir; dm_req = tbl[i].dr; dm_we = 1'b1;
      if_addr = 32'h4; dm_addr = 32'h40; dm_wdata = 32'hFFFF_FFFF; dm_wmask = 4'hF;
      #1;
      chk("rst_stall_if",  stall_if,  tbl[i].e_si);
      chk("rst_stall_mem", stall_mem, tbl[i].e_sm);
      chk("rst_outputs", {mem_req, mem_we, if_done, dm_done, mem_wmask}, 8'h00);
      chk("rst_data", {mem_addr, mem_wdata, if_rdata, dm_rdata}, 128'h0);
      @(negedge clk);
    end
    reset_dut(1);

    // ---- reset held 3 cycles mid-BUSY abandons a store to 0x40
    clear_logs();
    dm_q.push_back(mk(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF));
    step();
    step();
    dm_req = 1'b0; rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    dm_q.push_back(mk(1'b0, 32'h40, 32'h0, 4'h0));
    run_quiet(40);
    chk("rst_abandon_loads", dm_rd_log.size(), 1);
    if (dm_rd_log.size() == 1) chk("rst_abandon_data", dm_rd_log[0], init_val(16));

    // ---- lone fetches
    reset_dut(1); clear_logs();
    if_q.push_back(32'h4); if_q.push_back(32'h8);
    run_quiet(40);
    chk("fetch_grants", g_cyc.size(), 2);
    if (g_cyc.size() == 2) chk("fetch_spacing", g_cyc[1] - g_cyc[0], LAT + 2);
    if (if_rd_log.size() >= 1) chk("fetch_rdata", if_rd_log[0], init_val(1));

    // ---- simultaneous IF and DM load: DM first, IF 4 cycles later
    reset_dut(1); clear_logs();
    if_q.push_back(32'h8);
    dm_q.push_back(mk(1'b0, 32'h100, 32'h0, 4'h0));
    run_quiet(40);
    chk("prio_grants", g_cyc.size(), 2);
    if (g_cyc.size() == 2) begin
      chk("prio_first_dm",   g_dm[0], 1'b1);
      chk("prio_second_if",  g_dm[1], 1'b0);
      chk("prio_spacing",    g_cyc[1] - g_cyc[0], 4);
    end
    if (dm_rd_log.size() == 1) chk("prio_dm_rdata", dm_rd_log[0], init_val(64));
    if (if_rd_log.size() == 1) chk("prio_if_rdata", if_rd_log[0], init_val(2));

    // ---- DM streak: 6 stores against 2 fetches
    reset_dut(1); clear_logs();
    if_q.push_back(32'h10); if_q.push_back(32'h14);
    for (int i = 0; i < 6; i++)
      dm_q.push_back(mk(1'b1, 32'h200 + 32'(4 * i), 32'h1111_0000 + 32'(i), 4'hF));
    run_quiet(100);
    chk("streak_grants", g_dm.size(), 8);
    if (g_dm.size() == 8) begin
      bit exp_order [8];
      exp_order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) chk($sformatf("streak_order[%0d]", i), g_dm[i], exp_order[i]);
    end

    // ---- masked store then load
    reset_dut(1); clear_logs();
    dm_q.push_back(mk(1'b1, 32'h20, 32'hDEAD_BEEF, 4'b0011));
    dm_q.push_back(mk(1'b0, 32'h20, 32'h0, 4'h0));
    run_quiet(40);
    chk("mask_done_count", dm_rd_log.size(), 2);
    if (dm_rd_log.size() == 2) begin
      chk("mask_store_rdata", dm_rd_log[0], 32'h0);
      chk("mask_load_rdata",  dm_rd_log[1], (init_val(8) & 32'hFFFF_0000) | 32'h0000_BEEF);
    end

    // ---- randomized traffic with occasional resets
    gap_pct = 50;
    for (int k = 0; k < 600; k++) begin
      if (if_q.size() < 2 && $urandom_range(99) < 20)
        if_q.push_back({22'd0, 8'($urandom_range(255)), 2'b00});
      if (dm_q.size() < 2 && $urandom_range(99) < 30) begin
        d = mk(1'($urandom_range(1)), {22'd0, 8'($urandom_range(255)), 2'b00},
               $urandom, 4'($urandom_range(15)));
        dm_q.push_back(d);
      end
      rst = ($urandom_range(199) == 0);
      step();
    end
    rst = 1'b0;
    run_quiet(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire
